// File: rtl/spi_master_gen.sv
// SPI master with configurable word width, runtime SCLK divider, bit order,
// per-transfer CPOL/CPHA and one-hot chip selects with an optional hold between words.
`timescale 1ns/1ps
module spi_master_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CS     = 1,
   parameter int DIV_WIDTH  = 16,
   localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   input  logic [CSW-1:0]        cs_sel,
   input  logic                  cs_hold,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  sclk,
   output logic                  mosi,
   output logic [NUM_CS-1:0]     cs_n,
   input  logic                  miso
);

   localparam int BCW = $clog2(DATA_WIDTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PH_A  = 3'd2;
   localparam logic [2:0] S_PH_B  = 3'd3;
   localparam logic [2:0] S_LAG   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic                  lsb_q, lsb_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic                  hold_q, hold_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
   logic                  done_q, done_d;
   logic                  phase_end;

   // Active-low one-hot select; an index beyond NUM_CS selects nobody.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] idx);
      logic [NUM_CS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (CSW'(i) == idx) v[i] = 1'b0;
      end
      return v;
   endfunction

   assign phase_end = (cnt_q == div_q);
   assign tx_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign rx_data   = rx_data_q;
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign cs_n      = cs_n_q;

   // Next-state, phase timing and pin values; pins are set on the edge entering each state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      div_d     = div_q;
      hold_d    = hold_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      done_d    = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = phase_end ? '0 : cnt_q + DIV_WIDTH'(1);
      end

      case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            if (start) begin
               state_d   = S_SETUP;
               cnt_d     = '0;
               bit_cnt_d = '0;
               tx_sh_d   = tx_data;
               rx_sh_d   = '0;
               cpol_d    = cpol;
               cpha_d    = cpha;
               lsb_d     = lsb_first;
               div_d     = clk_div;
               hold_d    = cs_hold;
               mosi_d    = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
               cs_n_d    = cs_decode(cs_sel);
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               state_d = S_PH_A;
               sclk_d  = cpha_q ? ~cpol_q : cpol_q;
            end
         end
         S_PH_A: begin
            if (phase_end) begin
               state_d = S_PH_B;
               sclk_d  = cpha_q ? cpol_q : ~cpol_q;
               rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_WIDTH-1:1]}
                               : {rx_sh_q[DATA_WIDTH-2:0], miso};
            end
         end
         S_PH_B: begin
            if (phase_end) begin
               if (bit_cnt_q == BCW'(DATA_WIDTH-1)) begin
                  state_d = S_LAG;
                  sclk_d  = cpol_q;
               end else begin
                  state_d   = S_PH_A;
                  sclk_d    = cpha_q ? ~cpol_q : cpol_q;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  tx_sh_d   = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                  mosi_d    = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_WIDTH-2];
               end
            end
         end
         S_LAG: begin
            if (phase_end) begin
               state_d   = S_IDLE;
               sclk_d    = cpol;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               if (!hold_q) cs_n_d = '1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and pin registers; an asynchronous reset aborts any transfer silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         div_q     <= '0;
         hold_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         lsb_q     <= lsb_d;
         div_q     <= div_d;
         hold_q    <= hold_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: a driver pushes each accepted transfer,
// a negedge monitor plays the SPI slave and checks pins, handshake and results.
`timescale 1ns/1ps
module tb_spi_master_gen;

   localparam int DW     = 8;
   localparam int NCS    = 4;
   localparam int DVW    = 16;
   localparam int CSW    = 2;
   localparam int STATES = 2*DW + 2;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [DW-1:0]  tx_data = '0;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic           lsb_first = 1'b0;
   logic [DVW-1:0] clk_div = '0;
   logic [CSW-1:0] cs_sel = '0;
   logic           cs_hold = 1'b0;
   logic           miso = 1'b0;
   logic           tx_ready, busy, done, sclk, mosi;
   logic [DW-1:0]  rx_data;
   logic [NCS-1:0] cs_n;

   spi_master_gen #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DVW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
      .cs_sel(cs_sel), .cs_hold(cs_hold), .tx_ready(tx_ready), .busy(busy),
      .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            t;      // cycle in which start was presented
      int            td;     // cycle in which done must be high
      int            h;      // half-period in clk cycles
      logic          cpol, cpha, lsb, hold;
      int            sel;
      logic [DW-1:0] tx;     // word the slave must receive
      logic [DW-1:0] sw;     // word the slave returns
   } xfer_t;

   xfer_t xq[$];

   int   cyc = 0;
   logic last_cpol = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   last_td = 0;
   logic held_v = 1'b0;
   int   held_idx = 0;
   int   k = 0;
   logic [DW-1:0] rec = '0;
   logic prev_sclk = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [NCS-1:0] onehot_n(input int idx);
      logic [NCS-1:0] v;
      v = '1;
      if (idx >= 0 && idx < NCS) v[idx] = 1'b0;
      return v;
   endfunction

   function automatic logic sbit(input logic [DW-1:0] w, input logic lsb, input int j);
      return lsb ? w[j] : w[DW-1-j];
   endfunction

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      last_cpol <= reset_n ? cpol : 1'b0;
   end

   // Monitor, slave model and scoreboard consumer.
   always @(negedge clk) begin : mon
      xfer_t x;
      int    o, s, j;
      logic  es, lead, trail, samp, in_win, is_done;
      if (!reset_n) begin
         chk("rst_sclk", sclk, 0);
         chk("rst_cs_n", cs_n, {NCS{1'b1}});
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_ready", tx_ready, 1);
         chk("rst_rx", rx_data, 0);
         xq.delete();
         held_v    = 1'b0;
         miso      = 1'b0;
         prev_sclk = 1'b0;
      end else begin
         in_win = (xq.size() > 0) && (cyc >= xq[0].t + 1) && (cyc < xq[0].td);
         if (in_win) begin
            x = xq[0];
            o = cyc - (x.t + 1);
            s = o / x.h;
            if (s == 0 || s == STATES-1) es = x.cpol;
            else if (s % 2 == 1)         es = x.cpha ? ~x.cpol : x.cpol;
            else                         es = x.cpha ? x.cpol : ~x.cpol;
            chk("sclk", sclk, es);
            chk("busy", busy, 1);
            chk("ready", tx_ready, 0);
            chk("done", done, 0);
            chk("cs_n_active", cs_n, onehot_n(x.sel));
            if (cyc == x.t + 1) begin
               k    = 0;
               rec  = '0;
               miso = sbit(x.sw, x.lsb, 0);
            end else begin
               lead  = (prev_sclk == x.cpol) && (sclk != x.cpol);
               trail = (prev_sclk != x.cpol) && (sclk == x.cpol);
               samp  = x.cpha ? trail : lead;
               if (samp) begin
                  j = k;
                  if (j < DW) rec[x.lsb ? j : DW-1-j] = mosi;
                  k++;
                  if (k < DW) miso = sbit(x.sw, x.lsb, k);
               end
            end
         end else begin
            is_done = (xq.size() > 0) && (cyc == xq[0].td);
            chk("busy_idle", busy, 0);
            chk("ready_idle", tx_ready, 1);
            chk("done_idle", done, is_done);
            chk("sclk_idle", sclk, last_cpol);
            if (is_done) begin
               x        = xq.pop_front();
               held_v   = x.hold && (x.sel < NCS);
               held_idx = x.sel;
               chk("rx_data", rx_data, x.sw);
               chk("slave_rx_word", rec, x.tx);
               chk("sample_edges", k, DW);
            end
            chk("cs_n_idle", cs_n, held_v ? onehot_n(held_idx) : {NCS{1'b1}});
         end
         prev_sclk = sclk;
      end
   end

   // Present one accepted start (caller guarantees the model is idle) and push its expectation.
   task automatic do_start(input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                           input logic pol, input logic pha, input logic lsb,
                           input int div, input int sel, input logic hold);
      xfer_t x;
      tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb;
      clk_div = DVW'(div); cs_sel = CSW'(sel); cs_hold = hold; start = 1'b1;
      x.t = cyc; x.h = div + 1; x.td = cyc + 1 + x.h * STATES;
      x.cpol = pol; x.cpha = pha; x.lsb = lsb; x.hold = hold; x.sel = sel;
      x.tx = tx; x.sw = sw;
      xq.push_back(x);
      last_td = x.td;
      @(posedge clk); #2;
      start     = 1'b0;
      tx_data   = DW'($urandom);
      cpha      = 1'($urandom);
      lsb_first = 1'($urandom);
      clk_div   = DVW'($urandom);
      cs_sel    = CSW'($urandom);
      cs_hold   = 1'($urandom);
   endtask

   task automatic wait_idle(input int gap);
      while (cyc < last_td) begin @(posedge clk); #2; end
      repeat (gap) begin @(posedge clk); #2; end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin : driver
      int w;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_ready", tx_ready, 1);
      chk("reset_mosi", mosi, 0);
      chk("reset_cs_n", cs_n, 4'hF);
      reset_n = 1'b1;
      @(posedge clk); #2;

      // Mode 0, fastest clock, slave echoes the word.
      do_start(8'hA5, 8'hA5, 0, 0, 0, 0, 0, 0);
      wait_idle(2);

      // Mode 3, LSB first, H=4.
      cpol = 1'b1;
      @(posedge clk); #2;
      do_start(8'h3C, 8'h5A, 1, 1, 1, 3, 0, 0);
      wait_idle(3);

      // Held CS on slave 2, second word started in the done cycle.
      do_start(8'h11, 8'hC3, 0, 0, 0, 0, 2, 1);
      wait_idle(0);
      do_start(8'h22, 8'h96, 0, 0, 0, 0, 2, 0);
      wait_idle(2);

      // Held CS on slave 1 handed over to slave 3.
      do_start(8'h5E, 8'h71, 0, 1, 0, 1, 1, 1);
      wait_idle(4);
      do_start(8'hE7, 8'h18, 1, 0, 1, 0, 3, 0);
      wait_idle(2);

      // Extra starts and input changes mid-transfer are ignored.
      do_start(8'h6B, 8'hD2, 0, 0, 0, 1, 0, 0);
      repeat (5) begin @(posedge clk); #2; end
      start = 1'b1; tx_data = 8'hFF; cpol = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (7) begin @(posedge clk); #2; end
      start = 1'b1; tx_data = 8'h00; cs_sel = 2'd3;
      @(posedge clk); #2;
      start = 1'b0; cpol = 1'b0;
      wait_idle(2);

      // Reset pulsed in the middle of bit 5 of a mode 1 transfer with held CS.
      do_start(8'hBE, 8'h4D, 0, 1, 0, 1, 0, 1);
      repeat (22) begin @(posedge clk); #2; end
      reset_n = 1'b0;
      #1;
      chk("abort_sclk", sclk, 0);
      chk("abort_mosi", mosi, 0);
      chk("abort_cs_n", cs_n, 4'hF);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ready", tx_ready, 1);
      chk("abort_rx", rx_data, 0);
      last_td = 0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk); #2;
      do_start(8'hEF, 8'hBE, 0, 1, 0, 2, 1, 0);
      wait_idle(2);

      // Randomised transfers, including back-to-back starts in the done cycle.
      for (int i = 0; i < 24; i++) begin
         do_start(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 3), $urandom_range(0, NCS-1),
                  1'($urandom));
         wait_idle($urandom_range(0, 3));
      end

      wait_idle(3);
      chk("scoreboard_drained", xq.size(), 0);
      w = 0;
      while (!tx_ready && w < 100) begin @(posedge clk); #2; w++; end
      chk("final_ready", tx_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
